// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcode encodings, requester ids, payload structs and the
// legal-opcode check shared by the ALU arbiter and its issue sequencer.
package alu_arbiter_pkg;

    localparam int unsigned OP_W = 4;

    // ALU opcode encodings
    typedef enum logic [OP_W-1:0] {
        OP_ROL  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_ROR  = 4'b0010,
        OP_SRL  = 4'b0011,
        OP_ADD  = 4'b0100,
        OP_NAND = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_BTR  = 4'b1101
    } alu_op_e;

    // Requester id carried alongside an operation
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // ALU control bits travelling with an operation
    typedef struct packed {
        logic cin;
        logic inva;
        logic invb;
        logic sign;
    } alu_ctl_t;

    // ALU result flags
    typedef struct packed {
        logic ofl;
        logic zero;
        logic neg;
    } alu_flags_t;

    // Legal opcodes are the contiguous range ROL..SUB plus BTR
    function automatic logic op_legal(input logic [7:0] op);
        return (op <= 8'(OP_SUB)) || (op == 8'(OP_BTR));
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way grant with a round-robin "last winner" pointer.
// Build option ALU_ARB_PRIO0_EN: requester 0 always wins contention and the
// pointer register is not built.
// No grant is issued while rst or flush is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_PRIO0_EN

    // Clock is not needed without the pointer register
    logic w_unused_clk;
    assign w_unused_clk = clk;

    // Fixed priority: requester 0 first
    always_comb begin
        gnt = 2'b00;
        if (!rst && !flush) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

`else

    logic r_last;

    // Round-robin grant: under contention the requester other than last wins
    always_comb begin
        gnt = 2'b00;
        if (!rst && !flush) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer follows the winner; reset to 1 so requester 0 wins first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|gnt) begin
            r_last <= gnt[1];
        end
    end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter and issue sequencer for the shared ALU.
// Grants one request per cycle, registers it into an issue stage driving the
// ALU, then registers the ALU result into a response stage tagged by requester.
// Build option ALU_ARB_PRIO0_EN selects fixed priority for requester 0.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req0_inva,
    input  logic             req0_invb,
    input  logic             req0_sign,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic             req1_inva,
    input  logic             req1_invb,
    input  logic             req1_sign,

    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_inva,
    output logic             alu_invb,
    output logic             alu_sign,

    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ofl,
    input  logic             alu_zero,
    input  logic             alu_neg,

    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_ofl,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_err
);

    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    logic             w_any_gnt;
    logic [OPW-1:0]   w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    alu_ctl_t         w_sel_ctl;
    req_id_e          w_sel_id;
    logic             w_rsp_take;

    logic             r_iv;
    req_id_e          r_id;
    logic             r_err;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    alu_ctl_t         r_ctl;

    logic             r_rsp0_v;
    logic             r_rsp1_v;
    logic [WIDTH-1:0] r_rsp_out;
    alu_flags_t       r_rsp_flags;
    logic             r_rsp_err;

    assign w_req     = {req1_valid, req0_valid};
    assign w_any_gnt = |w_gnt;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    // Select the winning requester's operation
    always_comb begin
        w_sel_id  = REQ0;
        w_sel_op  = req0_op;
        w_sel_a   = req0_a;
        w_sel_b   = req0_b;
        w_sel_ctl = '{cin: req0_cin, inva: req0_inva, invb: req0_invb, sign: req0_sign};
        if (w_gnt[1]) begin
            w_sel_id  = REQ1;
            w_sel_op  = req1_op;
            w_sel_a   = req1_a;
            w_sel_b   = req1_b;
            w_sel_ctl = '{cin: req1_cin, inva: req1_inva, invb: req1_invb, sign: req1_sign};
        end
    end

    // Issue stage: fields are zeroed when nothing is issued so the ALU sees zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iv  <= 1'b0;
            r_id  <= REQ0;
            r_err <= 1'b0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_ctl <= '0;
        end else if (w_any_gnt) begin
            r_iv  <= 1'b1;
            r_id  <= w_sel_id;
            r_err <= !op_legal(8'(w_sel_op));
            r_op  <= w_sel_op;
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_ctl <= w_sel_ctl;
        end else begin
            r_iv  <= 1'b0;
            r_id  <= REQ0;
            r_err <= 1'b0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_ctl <= '0;
        end
    end

    assign alu_op   = r_op;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_cin  = r_ctl.cin;
    assign alu_inva = r_ctl.inva;
    assign alu_invb = r_ctl.invb;
    assign alu_sign = r_ctl.sign;

    // A flush at the edge drops the operation currently in the issue stage
    assign w_rsp_take = r_iv && !flush;

    // Response stage: one-cycle pulse per requester, shared bus holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_v    <= 1'b0;
            r_rsp1_v    <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp0_v <= w_rsp_take && (r_id == REQ0);
            r_rsp1_v <= w_rsp_take && (r_id == REQ1);
            if (w_rsp_take) begin
                r_rsp_err <= r_err;
                if (r_err) begin
                    r_rsp_out   <= '0;
                    r_rsp_flags <= '0;
                end else begin
                    r_rsp_out   <= alu_out;
                    r_rsp_flags <= '{ofl: alu_ofl, zero: alu_zero, neg: alu_neg};
                end
            end
        end
    end

    assign rsp0_valid = r_rsp0_v;
    assign rsp1_valid = r_rsp1_v;
    assign rsp_out    = r_rsp_out;
    assign rsp_ofl    = r_rsp_flags.ofl;
    assign rsp_zero   = r_rsp_flags.zero;
    assign rsp_neg    = r_rsp_flags.neg;
    assign rsp_err    = r_rsp_err;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and issue sequencer for the shared 16-bit ALU (`alu_hier`). The execute stage (requester 0) and the branch/address unit (requester 1) each present a full ALU operation with a valid/ready handshake. The block grants one request per cycle, registers it into an issue stage that drives the ALU, and registers the ALU result into a response stage tagged with the winning requester. It sits between the decode/execute control and the ALU instance.

## Interface
- `WIDTH`, default 16: datapath width. Must match the ALU.
- `OPW`, default 4: ALU opcode width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kills in-flight work; no accept this cycle.
- `reqN_valid`  in  1  (N=0,1) request present.
- `reqN_ready`  out  1  request accepted this cycle.
- `reqN_op`  in  OPW  ALU opcode.
- `reqN_a`, `reqN_b`  in  WIDTH  operands.
- `reqN_cin`, `reqN_inva`, `reqN_invb`, `reqN_sign`  in  1  ALU controls.
- `alu_op`  out  OPW  issue-stage drive to the ALU.
- `alu_a`, `alu_b`  out  WIDTH  issue-stage drive to the ALU.
- `alu_cin`, `alu_inva`, `alu_invb`, `alu_sign`  out  1  issue-stage drive to the ALU.
- `alu_out`  in  WIDTH  combinational ALU result.
- `alu_ofl`, `alu_zero`, `alu_neg`  in  1  combinational ALU flags.
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle response pulse to requester 0/1.
- `rsp_out`  out  WIDTH  shared response result bus.
- `rsp_ofl`, `rsp_zero`, `rsp_neg`, `rsp_err`  out  1  shared response flags.

## Operation
- **Grant**
  - Combinational from `req0_valid`, `req1_valid`, the round-robin pointer `last`, and `flush`.
  - Only one valid: that requester wins.
  - Both valid: the requester other than `last` wins.
  - `flush=1`: nothing is granted.
- **Ready**
  - `reqN_ready = grantN`.
  - Requesters must not derive valid from ready.
  - A request is held (no change to op or operands) until it is accepted.
- **Round-robin pointer**
  - `last` updates to the winner only on a grant.
  - Reset value is 1, so requester 0 wins the first contention.
- **Issue stage**
  - Captures the winner's fields plus `id` and `iv` (issue valid).
  - When `iv=0`, `alu_*` drive zeros.
- **Legal opcodes**
  - 0000–1000 and 1101 are legal.
  - Any other opcode sets `err` in the issue stage.
- **Response stage**
  - When `iv=1`, it registers `alu_out` and the three flags.
  - If `err=1`, result and flags are forced to 0 and `rsp_err=1`.
  - `rspN_valid` = response valid and `id==N`.
  - The shared bus holds its last value when no response is valid.
- **Backpressure:** none on responses. Every accepted request produces exactly one response pulse unless it is flushed.

## Timing
- **Reset values:** all `reqN_ready`, `rspN_valid`, `rsp_*` and `alu_*` outputs are 0; `iv=0`; `last=1`.
- **Latency:** accepted at edge N → `alu_*` driven during cycle N+1 → `rspX_valid` high in cycle N+2 for exactly one cycle.
- **Throughput:** one operation per cycle, back-to-back, with alternating grants under contention.
- **`flush` at an edge:**
  - clears `iv` and the response valid;
  - accepts nothing;
  - both in-flight operations are dropped and no `rsp*_valid` fires for them.
- **`rst` mid-operation:** same effect as flush, and `last` returns to 1.
- **`flush` and `rst` together:** reset dominates.
- **One requester valid every cycle:** it is granted every cycle; the pointer does not block it.

## Configuration
- `ALU_ARB_PRIO0_EN`
  - **Defined:** requester 0 always wins contention. `last` is not implemented, and requester 1 is granted only when `req0_valid=0`.
  - **Undefined:** round-robin as above.

## Structure
- **Shared include `alu_arb_defs.vh`**
  - ALU opcode constants (ROL, SLL, ROR, SRL, ADD, NAND, OR, XOR, SUB, BTR).
  - Requester id encodings.
  - The legal-op check as a macro or function.
- **Sub-module `rr_arb2`**
  - Contains the two-way grant logic and the `last` register.
  - Its ports are `clk`, `rst`, `flush`, `req[1:0]`, `gnt[1:0]`.
  - Under `ALU_ARB_PRIO0_EN` it reduces to fixed priority.

## Test plan
- **Single op:** after reset, `req0` ADD a=0x0003 b=0x0004 cin=0 → `req0_ready` on the first edge, `alu_a`=0x0003 the next cycle, `rsp0_valid`=1 and `rsp_out`=0x0007 two cycles after accept; `rsp1_valid` stays 0.
- **Contention:** both requesters valid continuously for 4 cycles → grants 0,1,0,1 and responses alternate id 0,1,0,1 starting at the 3rd cycle. With `ALU_ARB_PRIO0_EN` defined, the grants are 0,0,0,0.
- **Illegal op:** `req1` op=1010 → `rsp1_valid`=1, `rsp_err`=1, `rsp_out`=0x0000.
- **Flush:** accept `req0` XOR at edge N, assert `flush` at edge N+1 → no `rsp0_valid` at N+2 and `req0_ready`=0 during the flush cycle.
- **Reset mid-stream:** both requesters streaming, `rst` for one cycle → all valids and readys are 0 the next cycle, and the first contention after reset is granted to requester 0.
- **Scoreboard:** 1000 random ops on both requesters, checked against a reference model of the ALU → each response matches its own request, in order per requester, with zero drops.
